rr_grant_arb: RTL and testbench

RR_GRANT_ARB -- requirements
Module: rr_grant_arb

---
 rtl/rr_grant_arb.sv | 144 ++++++++++++++
 tb/tb_rr_grant_arb.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_grant_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_grant_arb : round-robin arbiter, one grant at a time, released by
// accept, reject or timeout.                                 Revision 1.0
// ---------------------------------------------------------------------------
module rr_grant_arb #(
  parameter int N       = 4,
  parameter int TIMEOUT = 15,
  localparam int PW     = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  input  logic [N-1:0]  req,
  input  logic          accept,
  input  logic          reject,
  output logic [N-1:0]  grant,
  output logic          grant_valid,
  output logic [PW-1:0] ptr,
  output logic          timeout_pulse
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [7:0]   TO_LIMIT  = 8'(TIMEOUT);
  localparam logic [N-1:0] ONE_HOT_0 = {{(N-1){1'b0}}, 1'b1};

  state_t        state;
  state_t        state_nxt;
  logic [N-1:0]  grant_nxt;
  logic          grant_valid_nxt;
  logic          timeout_nxt;
  logic [PW-1:0] ptr_nxt;
  logic [PW-1:0] gidx;
  logic [PW-1:0] gidx_nxt;
  logic [7:0]    wait_cnt;
  logic [7:0]    wait_cnt_nxt;
  logic [7:0]    wait_cnt_inc;

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  logic [PW-1:0]  rot_off;
  logic [PW-1:0]  sel_idx;
  logic           req_any;

  // Rotate the request vector so that bit 0 corresponds to the pointer;
  // the lowest set bit of the rotated vector is the winner.
  assign req_dbl = {req, req};
  assign req_rot = req_dbl[ptr +: N];
  assign req_any = |req;

  always_comb begin
    rot_off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        rot_off = PW'(i);
      end
    end
  end

  // N is a power of two, so the PW-bit add wraps modulo N.
  assign sel_idx      = ptr + rot_off;
  assign wait_cnt_inc = wait_cnt + 8'd1;

  always_comb begin
    state_nxt       = state;
    grant_nxt       = grant;
    grant_valid_nxt = grant_valid;
    ptr_nxt         = ptr;
    gidx_nxt        = gidx;
    wait_cnt_nxt    = wait_cnt;
    timeout_nxt     = 1'b0;

    unique case (state)
      IDLE: begin
        if (req_valid && req_any) begin
          state_nxt       = WAIT;
          grant_nxt       = ONE_HOT_0 << sel_idx;
          grant_valid_nxt = 1'b1;
          gidx_nxt        = sel_idx;
          wait_cnt_nxt    = '0;
        end else begin
          grant_nxt       = '0;
          grant_valid_nxt = 1'b0;
        end
      end

      WAIT: begin
        if (accept || reject || (wait_cnt_inc == TO_LIMIT)) begin
          state_nxt       = IDLE;
          grant_nxt       = '0;
          grant_valid_nxt = 1'b0;
          wait_cnt_nxt    = '0;
          if (accept) begin
            ptr_nxt = gidx + PW'(1);
          end else if (!reject) begin
            timeout_nxt = 1'b1;
          end
        end else begin
          wait_cnt_nxt = wait_cnt_inc;
        end
      end

      default: begin
        state_nxt       = IDLE;
        grant_nxt       = '0;
        grant_valid_nxt = 1'b0;
        wait_cnt_nxt    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      grant         <= '0;
      grant_valid   <= 1'b0;
      ptr           <= '0;
      gidx          <= '0;
      wait_cnt      <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      state         <= state_nxt;
      grant         <= grant_nxt;
      grant_valid   <= grant_valid_nxt;
      ptr           <= ptr_nxt;
      gidx          <= gidx_nxt;
      wait_cnt      <= wait_cnt_nxt;
      timeout_pulse <= timeout_nxt;
    end
  end

`ifndef SYNTHESIS
  a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(grant));
  a_valid_matches_grant : assert property (@(posedge clk) disable iff (!rst_n)
    grant_valid == (grant != '0));
`endif

endmodule
`default_nettype wire

// File: tb/tb_rr_grant_arb.sv
`default_nettype none
// Scoreboarded bench for rr_grant_arb: directed scenarios, then random traffic
// checked against a transaction-level round-robin model.
module tb_rr_grant_arb;

  localparam int N       = 4;
  localparam int TIMEOUT = 15;
  localparam int PW      = $clog2(N);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic [N-1:0]  req;
  logic          accept;
  logic          reject;
  logic [N-1:0]  grant;
  logic          grant_valid;
  logic [PW-1:0] ptr;
  logic          timeout_pulse;

  rr_grant_arb #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req           (req),
    .accept        (accept),
    .reject        (reject),
    .grant         (grant),
    .grant_valid   (grant_valid),
    .ptr           (ptr),
    .timeout_pulse (timeout_pulse)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input bit ok,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct { logic [N-1:0] g; logic [PW-1:0] p; } gexp_t;
  typedef struct { logic [PW-1:0] p; bit to; int cyc; } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];

  // Model state: priority pointer as a plain integer 0..N-1.
  int m_ptr = 0;

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // A cycle in IDLE that must not produce a grant.
  task automatic idle_cycle(input bit vld);
    req_valid = vld;
    req       = vld ? '0 : N'($urandom);
    accept    = 1'($urandom);
    reject    = 1'($urandom);
    step();
    chk("idle_no_grant", (grant_valid == 1'b0) && (grant == '0),
        {grant_valid, grant}, 0);
  endtask

  // resp: 0 timeout, 1 accept, 2 reject, 3 accept+reject, 4 reset with accept
  task automatic grant_txn(input logic [N-1:0] r, input int d, input int resp);
    int    idx;
    int    n_quiet;
    gexp_t ge;
    rexp_t re;
    idx  = pick(r, m_ptr);
    ge.g = '0;
    ge.g[idx] = 1'b1;
    ge.p = PW'(m_ptr);
    gq.push_back(ge);

    n_quiet = (resp == 0) ? TIMEOUT : d;
    re.cyc  = (resp == 0) ? TIMEOUT : d + 1;
    re.to   = (resp == 0);
    case (resp)
      1, 3:    m_ptr = (idx + 1) % N;
      4:       m_ptr = 0;
      default: ;
    endcase
    re.p = PW'(m_ptr);
    rq.push_back(re);

    req_valid = 1'b1;
    req       = r;
    accept    = 1'($urandom);
    reject    = 1'($urandom);
    step();
    for (int i = 0; i < n_quiet; i++) begin
      req_valid = 1'($urandom);
      req       = N'($urandom);
      accept    = 1'b0;
      reject    = 1'b0;
      step();
    end
    if (resp == 0) begin
      chk("timeout_release", (timeout_pulse == 1'b1) && (grant_valid == 1'b0),
          {timeout_pulse, grant_valid}, 2'b10);
    end else begin
      req_valid = 1'($urandom);
      req       = N'($urandom);
      accept    = (resp == 1) || (resp == 3) || (resp == 4);
      reject    = (resp == 2) || (resp == 3);
      if (resp == 4) rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("release", (grant_valid == 1'b0) && (grant == '0) && (ptr == PW'(m_ptr)),
          {grant_valid, grant, ptr}, {1'b0, {N{1'b0}}, PW'(m_ptr)});
    end
  endtask

  // Monitor: reacts to grant_valid edges and pops the scoreboard queues.
  bit           mon_en  = 1'b0;
  bit           prev_gv = 1'b0;
  logic [N-1:0] hold_g  = '0;
  int           hi      = 0;
  gexp_t        mge;
  rexp_t        mre;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("grant_shape", $onehot0(grant) && ((grant != '0) == grant_valid),
          {grant_valid, grant}, {grant_valid, grant & (~grant + 1'b1)});
      if (grant_valid && !prev_gv) begin
        if (gq.size() == 0) begin
          chk("unexpected_grant", 1'b0, grant, 0);
        end else begin
          mge = gq.pop_front();
          chk("grant", grant == mge.g, grant, mge.g);
          chk("ptr_at_grant", ptr == mge.p, ptr, mge.p);
          hold_g = mge.g;
        end
        hi = 1;
      end else if (grant_valid && prev_gv) begin
        chk("grant_hold", grant == hold_g, grant, hold_g);
        hi++;
      end else if (!grant_valid && prev_gv) begin
        if (rq.size() == 0) begin
          chk("unexpected_release", 1'b0, ptr, 0);
        end else begin
          mre = rq.pop_front();
          chk("ptr_after_release", ptr == mre.p, ptr, mre.p);
          chk("timeout_pulse", timeout_pulse == mre.to, timeout_pulse, mre.to);
          chk("wait_cycles", hi == mre.cyc, hi, mre.cyc);
        end
      end else begin
        chk("no_stray_timeout", timeout_pulse == 1'b0, timeout_pulse, 0);
      end
      prev_gv = grant_valid;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req       = '0;
    accept    = 1'b0;
    reject    = 1'b0;
    step();
    step();
    chk("reset_grant", grant == '0, grant, 0);
    chk("reset_grant_valid", grant_valid == 1'b0, grant_valid, 0);
    chk("reset_ptr", ptr == '0, ptr, 0);
    chk("reset_timeout", timeout_pulse == 1'b0, timeout_pulse, 0);
    rst_n  = 1'b1;
    m_ptr  = 0;
    mon_en = 1'b1;

    grant_txn(4'b1010, 0, 1);
    grant_txn(4'b0011, 2, 1);
    grant_txn(4'b0100, 0, 1);
    grant_txn(4'b1000, 1, 1);
    grant_txn(4'b0001, 0, 1);
    grant_txn(4'b0110, 3, 2);
    grant_txn(4'b0110, 0, 3);
    grant_txn(4'b0100, 0, 3);
    grant_txn(4'b0101, 0, 0);
    grant_txn(4'b0001, TIMEOUT - 1, 1);
    idle_cycle(1'b1);
    idle_cycle(1'b0);
    grant_txn(4'b1111, 4, 4);

    for (int t = 0; t < 300; t++) begin
      logic [N-1:0] r;
      int           sel;
      int           resp;
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) idle_cycle(1'($urandom));
      r = N'($urandom);
      if (r == '0) begin
        idle_cycle(1'b1);
      end else begin
        sel  = int'($urandom_range(0, 15));
        resp = (sel == 0) ? 0 : (sel == 1) ? 4 : (sel % 3) + 1;
        grant_txn(r, int'($urandom_range(0, TIMEOUT - 1)), resp);
      end
    end

    req_valid = 1'b0;
    req       = '0;
    accept    = 1'b0;
    reject    = 1'b0;
    repeat (3) step();
    chk("queues_drained", (gq.size() == 0) && (rq.size() == 0),
        gq.size() + rq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
